async_fifo_read_stream: RTL and testbench

//  Read-side consumer for the async FIFO. Runs in the read clock domain.

---
 rtl/async_fifo_read_stream.sv | 90 +++++++++
 tb/tb_async_fifo_read_stream.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/async_fifo_read_stream.sv
// Read-side consumer for the async FIFO: pops through the empty/enable port and re-presents
// the words as a valid/ready stream via a 2-entry skid buffer. Optional ASYNC_FIFO_RD_STATS_EN.
module async_fifo_read_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  read_clk,
    input  logic                  read_rst_n,
    input  logic                  p_read_empty,
    input  logic [DATA_WIDTH-1:0] p_read_data,
    output logic                  p_read_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef ASYNC_FIFO_RD_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  p_pop_count,
    output logic [CNT_WIDTH-1:0]  p_stall_count
`endif
);

    if (DATA_WIDTH == 0 || CNT_WIDTH == 0) begin : g_param_check
        $error("async_fifo_read_stream: DATA_WIDTH and CNT_WIDTH must be non-zero");
    end

    logic [DATA_WIDTH-1:0] buf_q [2];
    logic                  head_q;
    logic [1:0]            count_q;
    logic                  inflight_q;

    logic                  take;
    logic                  wr_idx;
    logic [1:0]            count_d;
    logic [2:0]            occupancy;

    always_comb begin
        m_valid   = (count_q != 2'd0);
        m_data    = buf_q[head_q];
        take      = m_valid && m_ready;
        // Slots committed after this edge: buffered + landing - leaving.
        occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, take};
        p_read_en = read_rst_n && !p_read_empty && (occupancy < 3'd2);
        // Landing slot is the first free one behind the current head; a same-cycle take
        // frees the head slot but does not move the tail.
        wr_idx    = head_q ^ count_q[0];
        count_d   = count_q + {1'b0, inflight_q} - {1'b0, take};
    end

    always_ff @(posedge read_clk) begin
        if (!read_rst_n) begin
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            head_q     <= 1'b0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= p_read_en;
            count_q    <= count_d;
            if (take) begin
                head_q <= ~head_q;
            end
            if (inflight_q) begin
                buf_q[wr_idx] <= p_read_data;
            end
        end
    end

`ifdef ASYNC_FIFO_RD_STATS_EN
    logic [CNT_WIDTH-1:0] pop_cnt_q;
    logic [CNT_WIDTH-1:0] stall_cnt_q;

    always_ff @(posedge read_clk) begin
        if (!read_rst_n) begin
            pop_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (p_read_en) begin
                pop_cnt_q <= pop_cnt_q + CNT_WIDTH'(1);
            end
            if (m_valid && !m_ready) begin
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign p_pop_count   = pop_cnt_q;
    assign p_stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_async_fifo_read_stream.sv
// Directed bench for async_fifo_read_stream: a behavioural FIFO feeds the read port and each
// cycle is compared against hand-derived expectations.
module tb_async_fifo_read_stream;

    logic        read_clk     = 1'b0;
    logic        read_rst_n   = 1'b0;
    logic        p_read_empty = 1'b1;
    logic [31:0] p_read_data  = '0;
    logic        p_read_en;
    logic        m_valid;
    logic        m_ready      = 1'b0;
    logic [31:0] m_data;
`ifdef ASYNC_FIFO_RD_STATS_EN
    logic [31:0] p_pop_count;
    logic [31:0] p_stall_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem [32];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    async_fifo_read_stream #(
        .DATA_WIDTH (32),
        .CNT_WIDTH  (32)
    ) dut (
        .read_clk      (read_clk),
        .read_rst_n    (read_rst_n),
        .p_read_empty  (p_read_empty),
        .p_read_data   (p_read_data),
        .p_read_en     (p_read_en),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data)
`ifdef ASYNC_FIFO_RD_STATS_EN
        ,
        .p_pop_count   (p_pop_count),
        .p_stall_count (p_stall_count)
`endif
    );

    always #5 read_clk = ~read_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = base + 32'(i);
            wr_ptr++;
        end
        p_read_empty = 1'b0;
    endtask

    // mask[0]: check p_read_en, mask[1]: check m_valid, mask[2]: check m_data
    task automatic step(input string tag, input logic e_en, input logic e_valid,
                        input logic [31:0] e_data, input logic [2:0] mask);
        logic pop;
        @(negedge read_clk);
        if (mask[0]) chk({tag, "_en"}, {31'b0, p_read_en}, {31'b0, e_en});
        if (mask[1]) chk({tag, "_valid"}, {31'b0, m_valid}, {31'b0, e_valid});
        if (mask[2]) chk({tag, "_data"}, m_data, e_data);
        if (p_read_empty) chk({tag, "_pop_while_empty"}, {31'b0, p_read_en}, 32'd0);
        pop = p_read_en;
        @(posedge read_clk);
        #1;
        if (pop) begin
            n_assert++;
            assert (rd_ptr != wr_ptr)
            else begin
                n_fail++;
                $error("FAIL %s_underflow: observed rd_ptr %0d expected below %0d",
                       tag, rd_ptr, wr_ptr);
            end
            if (rd_ptr != wr_ptr) begin
                p_read_data = mem[rd_ptr];
                rd_ptr++;
            end
        end
        p_read_empty = (rd_ptr == wr_ptr);
    endtask

    logic [11:0] en3  = 12'b000111000011;
    logic [11:0] val3 = 12'b011111111100;
    logic [7:0]  dat3 [12] = '{8'h00, 8'h00, 8'hB0, 8'hB0, 8'hB0, 8'hB0,
                               8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'h00};

    initial begin
        // Reset held with FIFO claiming data
        read_rst_n   = 1'b0;
        p_read_empty = 1'b0;
        @(posedge read_clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge read_clk);
            chk($sformatf("rst%0d_en", i), {31'b0, p_read_en}, 32'd0);
            chk($sformatf("rst%0d_valid", i), {31'b0, m_valid}, 32'd0);
            chk($sformatf("rst%0d_data", i), m_data, 32'd0);
            @(posedge read_clk);
            #1;
        end
        read_rst_n   = 1'b1;
        p_read_empty = 1'b1;
        step("idle", 1'b0, 1'b0, 32'd0, 3'b111);

        // Streaming at full rate
        m_ready = 1'b1;
        load(32'hA0, 8);
        for (int i = 0; i < 10; i++) begin
            step($sformatf("strm%0d", i), (i < 8), (i >= 2), 32'hA0 + 32'(i - 2),
                 {(i >= 2), 2'b11});
        end
        step("strm_end", 1'b0, 1'b0, 32'd0, 3'b011);

        // Backpressure: two words buffered, then drain with head wrap
        load(32'hB0, 5);
        for (int i = 0; i < 12; i++) begin
            m_ready = (i >= 6);
            step($sformatf("bp%0d", i), en3[i], val3[i], {24'b0, dat3[i]}, {val3[i], 2'b11});
        end
`ifdef ASYNC_FIFO_RD_STATS_EN
        chk("stats_pop", p_pop_count, 32'd13);
        chk("stats_stall", p_stall_count, 32'd4);
`endif

        // Single word, FIFO empties right after the pop
        load(32'hC5, 1);
        step("edge0", 1'b1, 1'b0, 32'd0, 3'b011);
        step("edge1", 1'b0, 1'b0, 32'd0, 3'b011);
        step("edge2", 1'b0, 1'b1, 32'hC5, 3'b111);
        step("edge3", 1'b0, 1'b0, 32'd0, 3'b011);

        // Reset with one word buffered and one in flight
        m_ready = 1'b0;
        load(32'hD0, 4);
        step("mrst0", 1'b1, 1'b0, 32'd0, 3'b011);
        step("mrst1", 1'b1, 1'b0, 32'd0, 3'b011);
        read_rst_n = 1'b0;
        step("mrst2", 1'b0, 1'b1, 32'hD0, 3'b001);
        read_rst_n = 1'b1;
        m_ready    = 1'b1;
`ifdef ASYNC_FIFO_RD_STATS_EN
        chk("stats_rst_pop", p_pop_count, 32'd0);
        chk("stats_rst_stall", p_stall_count, 32'd0);
`endif
        step("post0", 1'b1, 1'b0, 32'd0, 3'b111);
        step("post1", 1'b1, 1'b0, 32'd0, 3'b111);
        step("post2", 1'b0, 1'b1, 32'hD2, 3'b111);
        step("post3", 1'b0, 1'b1, 32'hD3, 3'b111);
        step("post4", 1'b0, 1'b0, 32'd0, 3'b011);
`ifdef ASYNC_FIFO_RD_STATS_EN
        chk("stats_post_pop", p_pop_count, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
